// File: rtl/force_accumulator.sv
// Per-particle force accumulator: pops {pid, fz, fy, fx} entries, adds them into a cache, streams out and clears on request.
// Optional macro FORCE_ACC_SATURATE_EN: saturating signed adds with a sticky sat_flag (default build wraps).
module force_accumulator #(
  parameter int ID_WIDTH         = 7,
  parameter int FORCE_WIDTH      = 32,
  parameter int CACHE_DEPTH      = 128,
  parameter int CACHE_ADDR_WIDTH = 7
) (
  input  logic                                  clock,
  input  logic                                  rst_n,
  input  logic                                  fifo_empty,
  output logic                                  fifo_rdreq,
  input  logic [ID_WIDTH+3*FORCE_WIDTH-1:0]     fifo_q,
  input  logic                                  readout_req,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CACHE_ADDR_WIDTH-1:0]           out_id,
  output logic [3*FORCE_WIDTH-1:0]              out_force,
  output logic                                  readout_done,
  output logic                                  busy,
  output logic                                  sat_flag
);

  localparam int FW = FORCE_WIDTH;
  localparam int DW = 3 * FORCE_WIDTH;
  localparam int AW = CACHE_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(CACHE_DEPTH - 1);

  localparam logic [2:0] S_CLEAR   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_POP     = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_ACC     = 3'd4;
  localparam logic [2:0] S_READOUT = 3'd5;

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic          rd_wait;
  logic [DW-1:0] force_lat;
  logic [AW-1:0] addr_lat;

  logic [DW-1:0] mem [CACHE_DEPTH];
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] sum_data;
  logic          last_accept;

  // Valid/ready: a readout entry transfers on any rising edge where out_valid && out_ready;
  // out_valid, out_id and out_force are held unchanged until that transfer.
  assign fifo_rdreq  = (state == S_POP);
  assign busy        = (state != S_IDLE);
  assign last_accept = (state == S_READOUT) && out_valid && out_ready && (idx == LAST);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

`ifdef FORCE_ACC_SATURATE_EN
  logic [2:0] comp_ovf;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_comp
    logic [FW-1:0] a, b, s;
    assign a = rd_data[g*FW +: FW];
    assign b = force_lat[g*FW +: FW];
    assign s = a + b;
`ifdef FORCE_ACC_SATURATE_EN
    // Overflow only when both operands share a sign the result does not; clamp toward that sign.
    assign comp_ovf[g] = (a[FW-1] == b[FW-1]) && (s[FW-1] != a[FW-1]);
    assign sum_data[g*FW +: FW] = comp_ovf[g] ? {a[FW-1], {(FW-1){~a[FW-1]}}} : s;
`else
    assign sum_data[g*FW +: FW] = s;
`endif
  end

`ifdef FORCE_ACC_SATURATE_EN
  logic sat_q;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (last_accept) begin
      sat_q <= 1'b0;
    end else if ((state == S_ACC) && (|comp_ovf)) begin
      sat_q <= 1'b1;
    end
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = idx;
    wr_en   = 1'b0;
    wr_addr = idx;
    wr_data = '0;
    case (state)
      S_CLEAR: wr_en = 1'b1;
      S_LOAD: begin
        rd_en   = 1'b1;
        rd_addr = fifo_q[DW +: AW];
      end
      S_ACC: begin
        wr_en   = 1'b1;
        wr_addr = addr_lat;
        wr_data = sum_data;
      end
      S_READOUT: begin
        rd_en = !out_valid && !rd_wait;
        wr_en = out_valid && out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CLEAR;
      idx          <= '0;
      rd_wait      <= 1'b0;
      force_lat    <= '0;
      addr_lat     <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      out_force    <= '0;
      readout_done <= 1'b0;
    end else begin
      readout_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end
        S_IDLE: begin
          if (readout_req) begin
            state   <= S_READOUT;
            idx     <= '0;
            rd_wait <= 1'b0;
          end else if (!fifo_empty) begin
            state <= S_POP;
          end
        end
        S_POP: state <= S_LOAD;
        S_LOAD: begin
          force_lat <= fifo_q[DW-1:0];
          addr_lat  <= fifo_q[DW +: AW];
          state     <= S_ACC;
        end
        S_ACC: begin
          if (readout_req) begin
            state   <= S_READOUT;
            idx     <= '0;
            rd_wait <= 1'b0;
          end else if (!fifo_empty) begin
            state <= S_POP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_READOUT: begin
          // Three-phase walk per address: issue read, capture data, wait for acceptance.
          if (out_valid) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (idx == LAST) begin
                state        <= S_IDLE;
                readout_done <= 1'b1;
                idx          <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end else if (rd_wait) begin
            rd_wait   <= 1'b0;
            out_valid <= 1'b1;
            out_id    <= idx;
            out_force <= rd_data;
          end else begin
            rd_wait <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_force_accumulator.sv
// Directed bench for force_accumulator: FIFO source model, reference accumulator model and readout scoreboard.
module tb_force_accumulator;

  localparam int IDW   = 7;
  localparam int FW    = 32;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 3 * FW;
  localparam int QW    = IDW + DW;
  localparam int EW    = AW + DW;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic [QW-1:0] fifo_q;
  logic          readout_req;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_id;
  logic [DW-1:0] out_force;
  logic          readout_done;
  logic          busy;
  logic          sat_flag;

  always #5 clock = ~clock;

  force_accumulator #(
    .ID_WIDTH(IDW), .FORCE_WIDTH(FW), .CACHE_DEPTH(DEPTH), .CACHE_ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .fifo_q(fifo_q), .readout_req(readout_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_force(out_force), .readout_done(readout_done), .busy(busy),
    .sat_flag(sat_flag)
  );

  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            rdreq_viol = 0;
  int            pulse_cyc[$];
  logic [QW-1:0] src_q[$];
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_sat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [FW-1:0] model_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
    longint s;
    logic [63:0] t;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef FORCE_ACC_SATURATE_EN
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647;
      model_sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648;
      model_sat = 1'b1;
    end
`endif
    t = s;
    return t[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] rnd_force();
    return FW'($urandom_range(0, 20000)) - 32'd10000;
  endfunction

  // One cycle: advance to the falling edge, then act as the upstream non-showahead FIFO.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (fifo_rdreq === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (fifo_empty || src_q.size() == 0) rdreq_viol++;
      else fifo_q = src_q.pop_front();
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic push(input logic [IDW-1:0] pid, input logic [FW-1:0] fx,
                      input logic [FW-1:0] fy, input logic [FW-1:0] fz);
    logic [DW-1:0] cur;
    src_q.push_back({pid, fz, fy, fx});
    fifo_empty = 1'b0;
    cur = model_mem[pid[AW-1:0]];
    model_mem[pid[AW-1:0]] = {model_add(cur[3*FW-1:2*FW], fz),
                              model_add(cur[2*FW-1:FW], fy),
                              model_add(cur[FW-1:0], fx)};
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    tick();
    while ((busy !== 1'b0 || !fifo_empty) && n < 2000) begin
      tick();
      n++;
    end
    check(tag, {busy, fifo_empty}, 2'b01);
  endtask

  task automatic check_sweep(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check(tag, n, 128);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " fifo_rdreq"}, fifo_rdreq, 1'b0);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " readout_done"}, readout_done, 1'b0);
    check({tag, " sat_flag"}, sat_flag, 1'b0);
    check({tag, " out_id"}, out_id, '0);
    check({tag, " out_force"}, out_force, '0);
  endtask

  // Snapshot the model into the expected queue, then drive the stream and score every visible entry.
  task automatic run_readout(input string tag, input bit toggle, input int abort_at);
    bit            last_acc = 1'b0;
    bit            done = 1'b0;
    int            guard = 0;
    logic [EW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({AW'(i), model_mem[i]});
      model_mem[i] = '0;
    end
    readout_req = 1'b1;
    while (!done && guard < 4000) begin
      tick();
      guard++;
      out_ready = toggle ? ~out_ready : 1'b1;
      if (out_valid === 1'b1) readout_req = 1'b0;
      check({tag, " readout_done"}, readout_done, last_acc);
      if (last_acc) begin
        done = 1'b1;
        model_sat = 1'b0;
        check({tag, " idle after done"}, busy, 1'b0);
      end else if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q[0];
        if (abort_at >= 0 && int'(e[EW-1:DW]) == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_reset_outs({tag, " async reset"});
          exp_q.delete();
          readout_req = 1'b0;
          out_ready = 1'b1;
          model_sat = 1'b0;
          return;
        end
        check({tag, " entry"}, {out_id, out_force}, e);
        if (out_ready) begin
          void'(exp_q.pop_front());
          last_acc = (exp_q.size() == 0);
        end
      end
    end
    check({tag, " all delivered"}, {done, 32'(exp_q.size())}, {1'b1, 32'd0});
    exp_q.delete();
    out_ready = 1'b1;
    readout_req = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    readout_req = 1'b0;
    out_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_q = '0;
    model_sat = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    tick();
    tick();
    check_reset_outs("reset");
    tick();
    rst_n = 1'b1;
    check_sweep("t21 clear sweep");
    check("t21 idle", busy, 1'b0);
    run_readout("t21 zeros", 1'b0, -1);

    // Two contributions to one particle; expect {8, 0, 6}.
    push(7'd5, 32'd10, -32'sd3, 32'd7);
    push(7'd5, -32'sd4, 32'd3, 32'd1);
    wait_idle("t22 drain");
    run_readout("t22", 1'b0, -1);

    pulse_cyc.delete();
    push(7'd1, rnd_force(), rnd_force(), rnd_force());
    push(7'd2, rnd_force(), rnd_force(), rnd_force());
    push(7'd127, rnd_force(), rnd_force(), rnd_force());
    push(7'($urandom_range(0, 127)), rnd_force(), rnd_force(), rnd_force());
    wait_idle("t23 drain");
    check("t23 pop count", pulse_cyc.size(), 4);
    for (int i = 0; i + 1 < pulse_cyc.size(); i++)
      check("t23 pop spacing", pulse_cyc[i+1] - pulse_cyc[i], 3);

    // Readout requested while the last entry is in ACC; its sum must be in the stream.
    push(7'($urandom_range(0, 127)), rnd_force(), rnd_force(), rnd_force());
    push(7'd5, rnd_force(), rnd_force(), rnd_force());
    wait_idle("t24 drain");
    push(7'd5, rnd_force(), rnd_force(), rnd_force());
    n = 0;
    tick();
    while (fifo_rdreq !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t24 pop seen", fifo_rdreq, 1'b1);
    tick();
    tick();
    readout_req = 1'b1;
    run_readout("t24 stalled", 1'b1, -1);
    run_readout("t24 second", 1'b0, -1);

    push(7'd9, 32'h7FFF_FFF0, 32'd0, 32'd0);
    push(7'd9, 32'h0000_0020, 32'd0, 32'd0);
    wait_idle("t25 drain");
    check("t25 sat_flag", sat_flag, model_sat);
    run_readout("t25", 1'b0, -1);
    check("t25 sat_flag cleared", sat_flag, model_sat);

    push(7'd40, rnd_force(), rnd_force(), rnd_force());
    push(7'd3, rnd_force(), rnd_force(), rnd_force());
    wait_idle("t26 drain");
    run_readout("t26", 1'b1, 40);
    tick();
    tick();
    rst_n = 1'b1;
    check_sweep("t26 clear sweep");
    run_readout("t26 zeros", 1'b0, -1);

    check("rdreq while empty", rdreq_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
